pipeline_stall_controller: RTL and testbench
============================================

// Module: pipeline_stall_controller
// PURPOSE
//  Central hazard/stall sequencer for the 5-stage MIPS pipeline. Generates the PC write enable,
//  the IF/ID write/flush, the ID/EX bubble, and the global pipeEnable that drives the hit input
//  of every pipeline register. Detects load-use hazards and taken branches, and runs a
//  miss-fill FSM that freezes the pipeline while the data cache is refilled.
// PARAMETERS
//  FILL_TIMEOUT  64  max cycles spent in FILL before giving up; sets missTimeout
//  COUNT_WIDTH   16  width of the saturating stall-cycle counter
// PORTS
//  clock         in   1            system clock; state updates on posedge
//  reset         in   1            asynchronous, active-high reset
//  memAccess     in   1            MEM stage holds a valid load/store this cycle
//  hit           in   1            data cache hit for the current MEM access
//  fillDone      in   1            memory finished the line fill; sampled only in FILL
//  idexMemRead   in   1            ID/EX holds a load
//  idexRT        in   5            load destination register in ID/EX
//  ifidRS        in   5            RS field of the instruction in IF/ID
//  ifidRT        in   5            RT field of the instruction in IF/ID
//  branchTaken   in   1            branch resolved taken in EX
//  pipeEnable    out  1            1 = all pipeline registers latch; 0 = freeze
//  pcWrite       out  1            PC register write enable
//  ifidWrite     out  1            IF/ID write enable
//  ifidFlush     out  1            IF/ID loads a NOP
//  idexBubble    out  1            ID/EX control fields forced to 0
//  fillRequest   out  1            line fill request to memory
//  missTimeout   out  1            sticky: a fill exceeded FILL_TIMEOUT
//  stallCount    out  COUNT_WIDTH  saturating count of stall cycles
// BEHAVIOUR
//  - FSM states: RUN, FILL, RESUME. Reset (async) -> RUN, waitCount=0, missTimeout=0,
//    stallCount=0. While reset=1, all outputs are 0. Reset during FILL drops fillRequest at once.
//  - miss = memAccess & ~hit, evaluated only in RUN.
//  - RUN: pipeEnable = ~miss (combinational, same cycle). If miss, next state = FILL.
//  - FILL: fillRequest=1; pipeEnable, pcWrite, ifidWrite, ifidFlush, idexBubble all 0.
//    waitCount increments from 0 each cycle.
//    * fillDone=1 -> RESUME.
//    * Else if waitCount==FILL_TIMEOUT-1 -> set missTimeout, go to RESUME.
//    * fillDone in the timeout cycle wins; missTimeout is not set.
//  - RESUME: one cycle, all enables 0 (cache presents refilled data), then RUN.
//    waitCount clears on RESUME.
//  - Hazard logic is active only when state==RUN and miss=0; otherwise its outputs are 0.
//    * Default outputs: pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0.
//    * loadUse = idexMemRead & (idexRT!=0) & (idexRT==ifidRS | idexRT==ifidRT).
//    * branchTaken=1: ifidFlush=1, idexBubble=1, pcWrite=1, ifidWrite=1. loadUse is ignored
//      (the instruction in ID is on the wrong path).
//    * Else loadUse=1: pcWrite=0, ifidWrite=0, idexBubble=1 for that cycle.
//  - branchTaken/loadUse during FILL/RESUME are ignored. The frozen EX stage re-presents
//    them after the return to RUN.
//  - stallCount increments by 1 on every posedge where pipeEnable=0, or where a loadUse stall
//    is issued (reset excluded). It saturates at all-ones and never wraps.
//  - missTimeout clears only on reset.
// TESTING
//  1. Reset: drive a miss, then assert reset in the 2nd FILL cycle -> fillRequest=0
//     immediately; after release: RUN, pipeEnable=1, stallCount=0.
//  2. Load-use: idexMemRead=1, idexRT=8, ifidRS=8 -> pcWrite=0, ifidWrite=0, idexBubble=1.
//     Same with idexRT=0 -> no stall.
//  3. Miss: memAccess=1, hit=0 at c0 -> pipeEnable=0 in c0, fillRequest=1 in c1-c4,
//     fillDone in c4, RESUME in c5, pipeEnable=1 in c6, stallCount=6.
//  4. Timeout: FILL_TIMEOUT=8, fillDone never asserted -> missTimeout=1 after the 8th FILL
//     cycle, then RESUME, then RUN. A second miss with fillDone at the 8th cycle leaves
//     missTimeout=1 and does not re-flag.
//  5. branchTaken=1 together with a load-use match -> ifidFlush=1, idexBubble=1, pcWrite=1,
//     ifidWrite=1.
//  6. branchTaken=1 during FILL -> no flush. With COUNT_WIDTH=4, 20 stall cycles ->
//     stallCount=15.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Hazard/stall sequencer: load-use and taken-branch control, plus a RUN/FILL/RESUME
// miss-fill FSM that freezes the pipeline while the data cache line is refilled.
module pipeline_stall_controller #(
  parameter int FILL_TIMEOUT = 64,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   memAccess,
  input  logic                   hit,
  input  logic                   fillDone,
  input  logic                   idexMemRead,
  input  logic [4:0]             idexRT,
  input  logic [4:0]             ifidRS,
  input  logic [4:0]             ifidRT,
  input  logic                   branchTaken,
  output logic                   pipeEnable,
  output logic                   pcWrite,
  output logic                   ifidWrite,
  output logic                   ifidFlush,
  output logic                   idexBubble,
  output logic                   fillRequest,
  output logic                   missTimeout,
  output logic [COUNT_WIDTH-1:0] stallCount
);
  localparam int WW = $clog2(FILL_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, FILL, RESUME} state_t;

  state_t                 r_state;
  logic [WW-1:0]          r_wait_cnt;
  logic                   r_fill_req;
  logic                   r_miss_timeout;
  logic [COUNT_WIDTH-1:0] r_stall_cnt;

  logic w_run;
  logic w_miss;
  logic w_pipe_en;
  logic w_load_use;
  logic w_lu_stall;
  logic w_stall_evt;

  assign w_run       = (r_state == RUN);
  assign w_miss      = w_run & memAccess & ~hit;
  assign w_pipe_en   = w_run & ~w_miss;
  assign w_load_use  = idexMemRead & (idexRT != 5'd0) &
                       ((idexRT == ifidRS) | (idexRT == ifidRT));
  // A taken branch squashes the ID instruction, so its load-use match is irrelevant.
  assign w_lu_stall  = w_pipe_en & ~branchTaken & w_load_use;
  assign w_stall_evt = ~w_pipe_en | w_lu_stall;

  assign pipeEnable  = w_pipe_en & ~reset;
  assign pcWrite     = w_pipe_en & ~w_lu_stall & ~reset;
  assign ifidWrite   = w_pipe_en & ~w_lu_stall & ~reset;
  assign ifidFlush   = w_pipe_en & branchTaken & ~reset;
  assign idexBubble  = w_pipe_en & (branchTaken | w_lu_stall) & ~reset;
  assign fillRequest = r_fill_req & ~reset;
  assign missTimeout = r_miss_timeout;
  assign stallCount  = r_stall_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_fill_req     <= 1'b0;
      r_miss_timeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_miss) begin
            r_state    <= FILL;
            r_fill_req <= 1'b1;
            r_wait_cnt <= '0;
          end
        end
        FILL: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (fillDone) begin
            r_state    <= RESUME;
            r_fill_req <= 1'b0;
          end else if (r_wait_cnt == WW'(FILL_TIMEOUT - 1)) begin
            r_state        <= RESUME;
            r_fill_req     <= 1'b0;
            r_miss_timeout <= 1'b1;
          end
        end
        RESUME: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
        default: begin
          r_state    <= RUN;
          r_fill_req <= 1'b0;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating: holds at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_evt && (r_stall_cnt != {COUNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboarded bench for pipeline_stall_controller: directed scenarios then random traffic.
module tb_pipeline_stall_controller;
  localparam int FT = 8;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          memAccess, hit, fillDone, idexMemRead, branchTaken;
  logic [4:0]    idexRT, ifidRS, ifidRT;
  logic          pipeEnable, pcWrite, ifidWrite, ifidFlush, idexBubble;
  logic          fillRequest, missTimeout;
  logic [CW-1:0] stallCount;

  pipeline_stall_controller #(.FILL_TIMEOUT(FT), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .memAccess(memAccess), .hit(hit), .fillDone(fillDone),
    .idexMemRead(idexMemRead), .idexRT(idexRT), .ifidRS(ifidRS), .ifidRT(ifidRT),
    .branchTaken(branchTaken), .pipeEnable(pipeEnable), .pcWrite(pcWrite),
    .ifidWrite(ifidWrite), .ifidFlush(ifidFlush), .idexBubble(idexBubble),
    .fillRequest(fillRequest), .missTimeout(missTimeout), .stallCount(stallCount)
  );

  typedef struct packed {
    logic          pe, pcw, ifw, fl, bub, fr, mt;
    logic [CW-1:0] sc;
  } exp_t;

  typedef struct {
    logic       rst, ma, h, fd, mr, br;
    logic [4:0] rt_x, rs_d, rt_d;
  } stim_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  stim_t s;

  // Reference model: pipeline mode, cycles spent filling, sticky timeout, stall total.
  typedef enum int {M_RUN, M_FILL, M_RESUME} mode_t;
  mode_t m_mode = M_RUN;
  int    m_fill_cycles = 0;
  bit    m_timeout = 0;
  int    m_stalls = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic clear_stim();
    s.rst = 0; s.ma = 0; s.h = 1; s.fd = 0; s.mr = 0; s.br = 0;
    s.rt_x = 0; s.rs_d = 0; s.rt_d = 0;
  endtask

  task automatic step(input string nm);
    exp_t e;
    bit   miss, flowing, lu;
    @(posedge clock);
    #1;
    reset = s.rst; memAccess = s.ma; hit = s.h; fillDone = s.fd;
    idexMemRead = s.mr; idexRT = s.rt_x; ifidRS = s.rs_d; ifidRT = s.rt_d;
    branchTaken = s.br;
    e = '0;
    if (s.rst) begin
      m_mode = M_RUN; m_fill_cycles = 0; m_timeout = 0; m_stalls = 0;
    end else begin
      miss    = (m_mode == M_RUN) && s.ma && !s.h;
      flowing = (m_mode == M_RUN) && !miss;
      lu      = s.mr && (s.rt_x != 0) && (s.rt_x == s.rs_d || s.rt_x == s.rt_d);
      e.pe  = flowing;
      e.pcw = flowing && (s.br || !lu);
      e.ifw = flowing && (s.br || !lu);
      e.fl  = flowing && s.br;
      e.bub = flowing && (s.br || lu);
      e.fr  = (m_mode == M_FILL);
      e.mt  = m_timeout;
      e.sc  = CW'(m_stalls);
      if (!flowing || (!s.br && lu)) m_stalls = (m_stalls < SAT) ? m_stalls + 1 : SAT;
      case (m_mode)
        M_RUN: if (miss) begin m_mode = M_FILL; m_fill_cycles = 0; end
        M_FILL: begin
          m_fill_cycles++;
          if (s.fd) m_mode = M_RESUME;
          else if (m_fill_cycles == FT) begin m_mode = M_RESUME; m_timeout = 1; end
        end
        default: m_mode = M_RUN;
      endcase
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  a, e;
    string nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{pe: pipeEnable, pcw: pcWrite, ifw: ifidWrite, fl: ifidFlush,
               bub: idexBubble, fr: fillRequest, mt: missTimeout, sc: stallCount};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got pe=%b pcw=%b ifw=%b fl=%b bub=%b fr=%b mt=%b sc=%0d, want pe=%b pcw=%b ifw=%b fl=%b bub=%b fr=%b mt=%b sc=%0d",
                   nm, a.pe, a.pcw, a.ifw, a.fl, a.bub, a.fr, a.mt, a.sc,
                   e.pe, e.pcw, e.ifw, e.fl, e.bub, e.fr, e.mt, e.sc);
        end
      end
    end
  end

  task automatic do_reset();
    clear_stim(); s.rst = 1;
    step("reset"); step("reset");
    s.rst = 0;
  endtask

  initial begin : stimulus
    int drain;
    reset = 1; memAccess = 0; hit = 1; fillDone = 0; idexMemRead = 0;
    idexRT = 0; ifidRS = 0; ifidRT = 0; branchTaken = 0;

    // Reset during FILL drops fillRequest immediately.
    do_reset();
    step("run_idle");
    s.ma = 1; s.h = 0; step("miss_c0");
    s.ma = 0; s.h = 1; step("fill_1");
    s.rst = 1; step("reset_in_fill2");
    s.rst = 0; step("after_reset");

    // Load-use on RS, on RT, and with r0 (no hazard).
    s.mr = 1; s.rt_x = 8; s.rs_d = 8; s.rt_d = 3; step("loaduse_rs");
    s.rs_d = 2; s.rt_d = 8; step("loaduse_rt");
    s.rt_x = 0; s.rs_d = 0; s.rt_d = 0; step("loaduse_r0");
    clear_stim();

    // Miss with fillDone on the 4th FILL cycle.
    do_reset();
    s.ma = 1; s.h = 0; step("miss3_c0");
    clear_stim();
    for (int i = 1; i <= 3; i++) step($sformatf("miss3_fill%0d", i));
    s.fd = 1; step("miss3_fill4_done");
    s.fd = 0; step("miss3_resume");
    step("miss3_run");
    step("miss3_run2");

    // Timeout, then a second miss whose fillDone lands on the last allowed cycle.
    do_reset();
    s.ma = 1; s.h = 0; step("to_miss");
    clear_stim();
    for (int i = 1; i <= FT; i++) step($sformatf("to_fill%0d", i));
    step("to_resume");
    step("to_run");
    s.ma = 1; s.h = 0; step("to2_miss");
    clear_stim();
    for (int i = 1; i < FT; i++) step($sformatf("to2_fill%0d", i));
    s.fd = 1; step("to2_fill_last_done");
    s.fd = 0; step("to2_resume");
    step("to2_run");

    // Taken branch overrides a load-use match.
    do_reset();
    s.br = 1; s.mr = 1; s.rt_x = 5; s.rs_d = 5; step("branch_over_loaduse");
    clear_stim();

    // Branch during FILL is ignored; long freezes saturate the counter.
    s.ma = 1; s.h = 0; step("brfill_miss");
    clear_stim(); s.br = 1;
    for (int i = 1; i <= 3; i++) step($sformatf("brfill_fill%0d", i));
    s.br = 0; s.fd = 1; step("brfill_done");
    clear_stim();
    for (int k = 0; k < 2; k++) begin
      s.ma = 1; s.h = 0; step("sat_miss");
      clear_stim();
      for (int i = 1; i <= FT; i++) step("sat_fill");
      step("sat_resume");
    end
    step("sat_run");

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s.rst  = ($urandom_range(0, 99) == 0);
      s.ma   = $urandom_range(0, 1);
      s.h    = ($urandom_range(0, 3) != 0);
      s.fd   = ($urandom_range(0, 4) == 0);
      s.mr   = $urandom_range(0, 1);
      s.br   = ($urandom_range(0, 4) == 0);
      s.rt_x = 5'($urandom_range(0, 3));
      s.rs_d = 5'($urandom_range(0, 3));
      s.rt_d = 5'($urandom_range(0, 3));
      step($sformatf("rand%0d", i));
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      @(posedge clock);
      drain++;
    end
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
